// File: rtl/scv_pkg.sv
// Shared types and constants for the EPOCH TV-1 video subsystem.
package scv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } vbank_state_t;

  // Read data returned for host accesses to a bank index that does not exist.
  localparam logic [63:0] VBANK_OOR_DATA = '1;

endpackage

// File: rtl/vram_bank_ram.sv
// Single-port synchronous-read RAM; one instance per VRAM bank.
module vram_bank_ram #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem_q [2**AWIDTH];
  logic [DWIDTH-1:0] rdata_q;

  // Contents are never cleared; rdata holds between reads.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vram_bank_ctrl.sv
// Banked VRAM: VDC chip-select port with priority, host port serviced on any
// bank the VDC is not selecting in the same cycle.
module vram_bank_ctrl
  import scv_pkg::*;
#(
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned AWIDTH     = 11,
  parameter int unsigned NBANKS     = 2,
  parameter int unsigned STARVE_MAX = 255,
  localparam int unsigned BW        = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
  input  logic                 CLK,
  input  logic                 RESB,
  input  logic                 CE,
  input  logic [AWIDTH-1:0]    VA,
  input  logic [DWIDTH-1:0]    VD_O,
  output logic [DWIDTH-1:0]    VD_I,
  input  logic                 nVWE,
  input  logic [NBANKS-1:0]    nVCS,
  input  logic                 B_REQ,
  input  logic                 B_WE,
  input  logic [BW+AWIDTH-1:0] B_A,
  input  logic [DWIDTH-1:0]    B_DI,
  output logic [DWIDTH-1:0]    B_DO,
  output logic                 B_ACK,
  output logic                 B_BUSY,
  output logic                 ERR_MULTICS,
  output logic                 B_STARVE,
  input  logic                 ERR_CLR
);

  localparam int unsigned CW    = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int unsigned NSLOT = 2 ** BW;

  vbank_state_t      state_q, state_d;
  logic [BW-1:0]     hbank_q, hbank_d;
  logic [AWIDTH-1:0] haddr_q, haddr_d;
  logic [DWIDTH-1:0] hdata_q, hdata_d;
  logic              hwe_q, hwe_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ack_q, ack_d, busy_q, busy_d;
  logic [DWIDTH-1:0] bdo_q, bdo_d, vdi_q, vdi_d;
  logic              vrd_vld_q, vrd_vld_d;
  logic [BW-1:0]     vrd_bank_q, vrd_bank_d;
  logic              multics_q, multics_d, starve_q, starve_d;

  logic              vdc_act_c, vdc_multi_c, host_blk_c, host_fire_c;
  logic [BW-1:0]     vdc_idx_c;
  logic [NBANKS-1:0] sel_c;
  logic [DWIDTH-1:0] rd_c [NSLOT];

  // Lowest-index active select wins.
  always_comb begin
    vdc_act_c = 1'b0;
    vdc_idx_c = '0;
    for (int i = int'(NBANKS) - 1; i >= 0; i--) begin
      if (!nVCS[i]) begin
        vdc_act_c = 1'b1;
        vdc_idx_c = BW'(i);
      end
    end
  end

  assign sel_c       = ~nVCS;
  assign vdc_multi_c = |(sel_c & (sel_c - NBANKS'(1)));
  assign host_blk_c  = vdc_act_c && (vdc_idx_c == hbank_q);
  assign host_fire_c = CE && (state_q == WAIT) && !host_blk_c;

  // Per-bank grant pair {vdc, host} is one-hot; out-of-range slots read as all-ones.
  for (genvar g = 0; g < int'(NSLOT); g++) begin : g_bank
    if (g < int'(NBANKS)) begin : g_ram
      logic vdc_gnt, host_gnt;
      assign vdc_gnt  = CE && vdc_act_c && (vdc_idx_c == BW'(g));
      assign host_gnt = host_fire_c && (hbank_q == BW'(g));
      vram_bank_ram #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_ram (
        .clk   (CLK),
        .we    (vdc_gnt ? !nVWE : (host_gnt && hwe_q)),
        .re    (vdc_gnt ? nVWE : (host_gnt && !hwe_q)),
        .addr  (vdc_gnt ? VA : haddr_q),
        .wdata (vdc_gnt ? VD_O : hdata_q),
        .rdata (rd_c[g])
      );
    end else begin : g_oor
      assign rd_c[g] = DWIDTH'(VBANK_OOR_DATA);
    end
  end

  always_comb begin
    state_d    = state_q;
    hbank_d    = hbank_q;
    haddr_d    = haddr_q;
    hdata_d    = hdata_q;
    hwe_d      = hwe_q;
    cnt_d      = cnt_q;
    ack_d      = ack_q;
    busy_d     = busy_q;
    bdo_d      = bdo_q;
    vdi_d      = vdi_q;
    vrd_vld_d  = vrd_vld_q;
    vrd_bank_d = vrd_bank_q;
    multics_d  = multics_q;
    starve_d   = starve_q;
    if (CE) begin
      vrd_vld_d  = vdc_act_c && nVWE;
      vrd_bank_d = vdc_idx_c;
      if (vrd_vld_q) vdi_d = rd_c[vrd_bank_q];
      // Clear first so a same-cycle set takes precedence.
      if (ERR_CLR) begin
        multics_d = 1'b0;
        starve_d  = 1'b0;
      end
      if (vdc_multi_c) multics_d = 1'b1;
      ack_d = (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (B_REQ) begin
            hbank_d = B_A[BW+AWIDTH-1 -: BW];
            haddr_d = B_A[AWIDTH-1:0];
            hdata_d = B_DI;
            hwe_d   = B_WE;
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (host_blk_c) begin
            if (cnt_q != CW'(STARVE_MAX)) begin
              cnt_d = cnt_q + CW'(1);
              if (cnt_d == CW'(STARVE_MAX)) starve_d = 1'b1;
            end
          end else begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
          if (!hwe_q) bdo_d = rd_c[hbank_q];
        end
        default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE) || (state_q == DONE);
    end
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q    <= IDLE;
      hbank_q    <= '0;
      haddr_q    <= '0;
      hdata_q    <= '0;
      hwe_q      <= 1'b0;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      bdo_q      <= '0;
      vdi_q      <= '0;
      vrd_vld_q  <= 1'b0;
      vrd_bank_q <= '0;
      multics_q  <= 1'b0;
      starve_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hbank_q    <= hbank_d;
      haddr_q    <= haddr_d;
      hdata_q    <= hdata_d;
      hwe_q      <= hwe_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      bdo_q      <= bdo_d;
      vdi_q      <= vdi_d;
      vrd_vld_q  <= vrd_vld_d;
      vrd_bank_q <= vrd_bank_d;
      multics_q  <= multics_d;
      starve_q   <= starve_d;
    end
  end

  assign VD_I        = vdi_q;
  assign B_DO        = bdo_q;
  assign B_ACK       = ack_q;
  assign B_BUSY      = busy_q;
  assign ERR_MULTICS = multics_q;
  assign B_STARVE    = starve_q;

endmodule

// File: doc/vram_bank_ctrl.md
# vram_bank_ctrl

Parametrised VRAM subsystem for the EPOCH TV-1 video path. Provides `NBANKS` independent synchronous banks behind the VDC's chip-select bus, plus a second, lower-priority host port for debug and savestate access. The host port is serviced concurrently on any bank the VDC is not selecting. It replaces the fixed two-bank arrangement with defined hold behaviour, error flags and bank-parallel host access.

## Interface
- `DWIDTH`, 8, data width per bank
- `AWIDTH`, 11, address width per bank
- `NBANKS`, 2, bank count, 1..8; `BW = $clog2(NBANKS)`, minimum 1
- `STARVE_MAX`, 255, host wait-cycle limit before the starve flag sets
- Clock and reset: one clock; reset is asynchronous and active-low.
- `CLK`  in  1  system clock
- `RESB`  in  1  async active-low reset
- `CE`  in  1  clock enable; all state advances only when `CE`=1
- `VA`  in  AWIDTH  VDC address
- `VD_O`  in  DWIDTH  VDC write data
- `VD_I`  out  DWIDTH  read data to the VDC
- `nVWE`  in  1  VDC write strobe, active low
- `nVCS`  in  NBANKS  VDC bank selects, active low
- `B_REQ`  in  1  host request, level
- `B_WE`  in  1  host write (1) / read (0)
- `B_A`  in  BW+AWIDTH  host address; upper BW bits select the bank
- `B_DI`  in  DWIDTH  host write data
- `B_DO`  out  DWIDTH  host read data
- `B_ACK`  out  1  host access complete
- `B_BUSY`  out  1  host request in flight
- `ERR_MULTICS`  out  1  sticky: more than one `nVCS` bit was low
- `B_STARVE`  out  1  sticky: host wait reached `STARVE_MAX`
- `ERR_CLR`  in  1  clears both sticky flags

## Operation
- **VDC port**
  - On each CE cycle, the active bank is the lowest index with `nVCS[i]`=0.
  - If `nVWE`=0, `VD_O` is written to `bank[VA]`. Otherwise `bank[VA]` is read and registered into `VD_I`.
  - If more than one select is low, the lowest index still wins and `ERR_MULTICS` is set.
  - If no select is low, `VD_I` holds its last value and no bank is touched.
- **Host FSM**, states `IDLE`, `WAIT`, `DONE`:
  - `IDLE`: on `B_REQ`=1, latch `B_A`, `B_DI` and `B_WE`. Clear the wait counter, set `B_BUSY`, go to `WAIT`.
  - `WAIT`: the access fires in any CE cycle where the latched bank is not the VDC's active bank.
    - On a write, store the data. On a read, register the data into `B_DO`. Then go to `DONE`.
    - In every blocked cycle, the counter increments and saturates at `STARVE_MAX`. When it reaches `STARVE_MAX`, `B_STARVE` is set.
    - The VDC is never stalled or overridden.
  - `DONE`: `B_ACK`=1 for exactly this one CE cycle and `B_BUSY` stays 1. Then go to `IDLE` with `B_BUSY`=0.
  - `B_REQ` still high in `IDLE` is treated as a new request. The earliest back-to-back issue is the CE cycle after `DONE`.
- `B_A` with a bank index ≥ `NBANKS` completes as a no-op. A read returns all-ones and `B_ACK` behaves as normal.
- If `ERR_CLR` and a new flag condition occur in the same cycle, the set wins.

## Timing
- **Reset values:** `VD_I`=0, `B_DO`=0, `B_ACK`=0, `B_BUSY`=0, `ERR_MULTICS`=0, `B_STARVE`=0, FSM in `IDLE`. Memory contents are undefined and are not cleared.
- **Reset mid-access:** an in-flight host request is aborted without acknowledge. A write in the reset cycle is not guaranteed.
- **VDC read latency:** 1 CE cycle. Address is sampled on CE edge n and `VD_I` is valid after edge n+1. With `CE`=0, `VD_I` holds.
- **Host latency:**
  - Unblocked: `B_REQ` sampled at edge n, access at n+1, `B_ACK` high after n+2.
  - Blocked: each blocked CE cycle adds 1.
  - `B_DO` is valid when `B_ACK`=1 and holds until the next host read.
- **Same bank and address, same cycle:** the VDC and host never access one bank in the same cycle, so no write collision is possible.
- **Different banks:** VDC and host accesses complete in the same CE cycle.

## Structure
- `scv_pkg` additions:
  - `vbank_state_t` (`IDLE`/`WAIT`/`DONE`)
  - constant `VBANK_OOR_DATA` (all-ones fill)
- Sub-module `vram_bank_ram`: single-port, synchronous-read RAM of `DWIDTH` × `2**AWIDTH`, with write and read enables. Instantiate it `NBANKS` times in a generate loop.
- Each bank's port mux (VDC or host) is combinational. Selection is by one-hot grant per bank.

## Test plan
- **VDC write/read:** `NBANKS`=2; VDC writes 8'hA5 to bank1 addr 0x123, then reads it → `VD_I`=8'hA5 one CE cycle after the read; bank0 addr 0x123 unchanged.
- **Parallel access:** VDC continuously reads bank0; host writes 8'h3C to bank1 addr 0x010 → `B_ACK` 2 CE cycles after `B_REQ`; a subsequent VDC read of bank1 returns 8'h3C.
- **Starvation:** `STARVE_MAX`=4; VDC holds bank0 selected for 10 cycles while the host reads bank0 → `B_STARVE`=1 after 4 blocked cycles; `B_ACK` follows the first cycle `nVCS[0]`=1; `ERR_CLR` then returns the flag to 0.
- **Multiple selects:** `nVCS`=2'b00 with a write of 8'h77 → only bank0 is written; `ERR_MULTICS`=1 and stays set until `ERR_CLR`.
- **Out-of-range bank:** `NBANKS`=3; host read of bank index 3 → `B_DO`=all-ones, one `B_ACK` pulse, no bank modified.
- **Reset mid-request:** `RESB` low while the host is in `WAIT` → all outputs return to reset values; no `B_ACK` is produced; the next request completes normally.
